// File: rtl/motor_pos_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | motor_pos_ctrl                                                             |
// | Single-axis DC motor position controller: filtered encoder, clamped        |
// | target, saturating position and latched stall fault.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module motor_pos_ctrl #(
  parameter int POS_W        = 8,
  parameter int PPR          = 24,
  parameter int MAX_POS      = 95,
  parameter int FILT_CYCLES  = 131072,
  parameter int STALL_CYCLES = 16777216
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [POS_W-1:0] target_pos,
  input  logic             abort,
  input  logic             fault_clr,
  input  logic             encoder,
  output logic             en,
  output logic [1:0]       ctl,
  output logic             done,
  output logic             fault,
  output logic [POS_W-1:0] cur_pos,
  output logic [1:0]       state_dbg
);

  localparam int c_FILT_W  = (FILT_CYCLES < 2) ? 1 : $clog2(FILT_CYCLES);
  localparam int c_PPR_W   = $clog2(PPR);
  localparam int c_STALL_W = (STALL_CYCLES < 2) ? 1 : $clog2(STALL_CYCLES + 1);

  localparam logic [c_FILT_W-1:0]  c_FILT_LAST = c_FILT_W'(FILT_CYCLES - 1);
  localparam logic [c_PPR_W-1:0]   c_PPR_LAST  = c_PPR_W'(PPR - 1);
  localparam logic [c_STALL_W-1:0] c_STALL_MAX = c_STALL_W'(STALL_CYCLES);
  localparam logic [POS_W-1:0]     c_MAX_POS   = POS_W'(MAX_POS);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_MOVE  = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;
  localparam logic [1:0] c_FAULT = 2'd3;

  logic [1:0]           r_sync;
  logic                 r_filt;
  logic                 r_filt_d;
  logic [c_FILT_W-1:0]  r_filt_cnt;
  logic [1:0]           r_state;
  logic [1:0]           w_next;
  logic [POS_W-1:0]     r_pos;
  logic [POS_W-1:0]     r_tgt;
  logic                 r_dir;
  logic [c_PPR_W-1:0]   r_pulse;
  logic [c_STALL_W-1:0] r_stall;
  logic                 w_strobe;
  logic                 w_accept;
  logic                 w_stall_hit;
  logic [POS_W-1:0]     w_tgt_clamp;

  // The filtered level only moves after FILT_CYCLES uninterrupted disagreements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= '0;
      r_filt     <= 1'b0;
      r_filt_d   <= 1'b0;
      r_filt_cnt <= '0;
    end else begin
      r_sync   <= {r_sync[0], encoder};
      r_filt_d <= r_filt;
      if (r_sync[1] == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == c_FILT_LAST) begin
        r_filt     <= ~r_filt;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + c_FILT_W'(1);
      end
    end
  end

  assign w_strobe    = r_filt & ~r_filt_d;
  assign w_tgt_clamp = (target_pos > c_MAX_POS) ? c_MAX_POS : target_pos;
  assign w_accept    = (r_state == c_IDLE) && load && !abort;
  // A strobe landing on the expiry cycle clears the stall count, so it suppresses the fault.
  assign w_stall_hit = (STALL_CYCLES != 0) && (r_stall == c_STALL_MAX) && !w_strobe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          w_next = (r_pos == w_tgt_clamp) ? c_DONE : c_MOVE;
        end
      end
      c_MOVE: begin
        if (abort) begin
          w_next = c_IDLE;
        end else if (r_pos == r_tgt) begin
          w_next = c_DONE;
        end else if (w_stall_hit) begin
          w_next = c_FAULT;
        end
      end
      c_DONE: begin
        if (!load || abort) begin
          w_next = c_IDLE;
        end
      end
      c_FAULT: begin
        if (fault_clr && !load) begin
          w_next = c_IDLE;
        end
      end
      default: w_next = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos   <= '0;
      r_tgt   <= '0;
      r_dir   <= 1'b0;
      r_pulse <= '0;
      r_stall <= '0;
    end else if (w_accept) begin
      r_tgt   <= w_tgt_clamp;
      r_dir   <= (r_pos > w_tgt_clamp);
      r_pulse <= '0;
      r_stall <= '0;
    end else if (r_state == c_MOVE) begin
      if (w_strobe) begin
        r_stall <= '0;
        if (r_pulse == c_PPR_LAST) begin
          r_pulse <= '0;
          if (r_dir) begin
            if (r_pos != '0) r_pos <= r_pos - POS_W'(1);
          end else begin
            if (r_pos != c_MAX_POS) r_pos <= r_pos + POS_W'(1);
          end
        end else begin
          r_pulse <= r_pulse + c_PPR_W'(1);
        end
      end else if (r_stall != c_STALL_MAX) begin
        r_stall <= r_stall + c_STALL_W'(1);
      end
    end
  end

  always_comb begin
    en        = (r_state == c_MOVE);
    ctl       = 2'b00;
    done      = (r_state == c_DONE);
    fault     = (r_state == c_FAULT);
    cur_pos   = r_pos;
    state_dbg = r_state;
    if (r_state == c_MOVE) begin
      ctl = r_dir ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire
